// File: rtl/regfile_pkg.sv
// rtl/regfile_pkg.sv - default sizes and types for the scoreboarded register file
package regfile_pkg;

    localparam int REGFILE_DATA_W = 16;
    localparam int REGFILE_ADDR_W = 4;
    localparam int REGFILE_NUM_RD = 2;
    localparam int REGFILE_DEPTH  = 2 ** REGFILE_ADDR_W;

    typedef logic [REGFILE_ADDR_W-1:0] regfile_addr_t;
    typedef logic [REGFILE_DATA_W-1:0] regfile_data_t;

endpackage

// File: rtl/regfile_read_port.sv
// rtl/regfile_read_port.sv - one combinational read port with write bypass
// Honours REGFILE_ZERO_REG_EN: address 0 reads as 0 and never busy.
module regfile_read_port
    import regfile_pkg::*;
#(
    parameter int DATA_W = REGFILE_DATA_W,
    parameter int ADDR_W = REGFILE_ADDR_W,
    parameter int DEPTH  = 2 ** ADDR_W
) (
    input  logic [ADDR_W-1:0] rd_addr_i,
    input  logic [DATA_W-1:0] regs_i [DEPTH],
    input  logic [DEPTH-1:0]  busy_i,
    input  logic              wr_en_i,
    input  logic [ADDR_W-1:0] wr_addr_i,
    input  logic [DATA_W-1:0] wr_data_i,
    output logic [DATA_W-1:0] rd_data_o,
    output logic              rd_busy_o
);

    always_comb begin
        rd_data_o = regs_i[rd_addr_i];
        rd_busy_o = busy_i[rd_addr_i];
        // Writeback in flight this cycle is the newest value and retires the producer
        if (wr_en_i && (wr_addr_i == rd_addr_i)) begin
            rd_data_o = wr_data_i;
            rd_busy_o = 1'b0;
        end
`ifdef REGFILE_ZERO_REG_EN
        if (rd_addr_i == '0) begin
            rd_data_o = '0;
            rd_busy_o = 1'b0;
        end
`endif
    end

endmodule

// File: rtl/regfile_sb.sv
// rtl/regfile_sb.sv - multi-read-port register file with bypass and busy scoreboard
// Optional REGFILE_ZERO_REG_EN hardwires register 0 to zero and never busy.
module regfile_sb
    import regfile_pkg::*;
#(
    parameter int DATA_W = REGFILE_DATA_W,
    parameter int ADDR_W = REGFILE_ADDR_W,
    parameter int NUM_RD = REGFILE_NUM_RD,
    parameter int DEPTH  = 2 ** ADDR_W
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
    output logic [NUM_RD*DATA_W-1:0] rd_data,
    output logic [NUM_RD-1:0]        rd_busy,
    input  logic                     wr_en,
    input  logic [ADDR_W-1:0]        wr_addr,
    input  logic [DATA_W-1:0]        wr_data,
    input  logic                     set_busy,
    input  logic [ADDR_W-1:0]        set_addr,
    output logic [DEPTH-1:0]         busy_vec
);

    logic [DATA_W-1:0] regs_q [DEPTH];
    logic [DATA_W-1:0] regs_d [DEPTH];
    logic [DEPTH-1:0]  busy_q;
    logic [DEPTH-1:0]  busy_d;
    logic              wr_ok;
    logic              set_ok;

`ifdef REGFILE_ZERO_REG_EN
    assign wr_ok  = wr_en    && (wr_addr  != '0);
    assign set_ok = set_busy && (set_addr != '0);
`else
    assign wr_ok  = wr_en;
    assign set_ok = set_busy;
`endif

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            regs_d[i] = regs_q[i];
        end
        busy_d = busy_q;
        if (wr_ok) begin
            regs_d[wr_addr] = wr_data;
            busy_d[wr_addr] = 1'b0;
        end
        // Applied after the write so a same-address issue (newer producer) wins
        if (set_ok) begin
            busy_d[set_addr] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs_q[i] <= '0;
            end
            busy_q <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                regs_q[i] <= regs_d[i];
            end
            busy_q <= busy_d;
        end
    end

    assign busy_vec = busy_q;

    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
        regfile_read_port #(
            .DATA_W (DATA_W),
            .ADDR_W (ADDR_W),
            .DEPTH  (DEPTH)
        ) u_port (
            .rd_addr_i (rd_addr[k*ADDR_W +: ADDR_W]),
            .regs_i    (regs_q),
            .busy_i    (busy_q),
            .wr_en_i   (wr_en),
            .wr_addr_i (wr_addr),
            .wr_data_i (wr_data),
            .rd_data_o (rd_data[k*DATA_W +: DATA_W]),
            .rd_busy_o (rd_busy[k])
        );
    end

endmodule

// File: tb/tb_regfile_sb.sv
// tb/tb_regfile_sb.sv - directed self-checking bench for regfile_sb
module tb_regfile_sb;
    import regfile_pkg::*;

    logic        clk;
    logic        reset;
    logic [7:0]  rd_addr;
    logic [31:0] rd_data;
    logic [1:0]  rd_busy;
    logic        wr_en;
    logic [3:0]  wr_addr;
    logic [15:0] wr_data;
    logic        set_busy;
    logic [3:0]  set_addr;
    logic [15:0] busy_vec;

    int checks = 0;
    int errors = 0;

    regfile_sb dut (
        .clk      (clk),
        .reset    (reset),
        .rd_addr  (rd_addr),
        .rd_data  (rd_data),
        .rd_busy  (rd_busy),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .set_busy (set_busy),
        .set_addr (set_addr),
        .busy_vec (busy_vec)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        wr_en    = 1'b0;
        wr_addr  = '0;
        wr_data  = '0;
        set_busy = 1'b0;
        set_addr = '0;
    endtask

    // Apply inputs just after the falling edge, settle, leaving time to check before the rising edge.
    task automatic drive(input logic we, input logic [3:0] wa, input logic [15:0] wd,
                         input logic sb, input logic [3:0] sa,
                         input logic [3:0] a0, input logic [3:0] a1);
        @(negedge clk);
        wr_en    = we;
        wr_addr  = wa;
        wr_data  = wd;
        set_busy = sb;
        set_addr = sa;
        rd_addr  = {a1, a0};
        #1;
    endtask

    task automatic edge_then_idle(input logic [3:0] a0, input logic [3:0] a1);
        @(posedge clk);
        #1;
        idle();
        rd_addr = {a1, a0};
        #1;
    endtask

    initial begin
        reset = 1'b0;
        idle();
        rd_addr = '0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        check("reset_busy_vec", {16'h0, busy_vec}, 32'h0);
        check("reset_rd_data", rd_data, 32'h0);
        check("reset_rd_busy", {30'h0, rd_busy}, 32'h0);

        // Preload r5 and mark it busy, then reset with concurrent strobes
        drive(1'b1, 4'd5, 16'hBEEF, 1'b0, 4'd0, 4'd5, 4'd5);
        edge_then_idle(4'd5, 4'd5);
        drive(1'b0, 4'd0, 16'h0, 1'b1, 4'd5, 4'd5, 4'd5);
        edge_then_idle(4'd5, 4'd5);
        check("preload_r5_data", {16'h0, rd_data[15:0]}, 32'h0000BEEF);
        check("preload_r5_busy", {16'h0, busy_vec}, 32'h00000020);
        check("preload_rd_busy", {30'h0, rd_busy}, 32'h3);

        drive(1'b1, 4'd6, 16'h1111, 1'b1, 4'd6, 4'd5, 4'd6);
        reset = 1'b0;
        edge_then_idle(4'd5, 4'd6);
        reset = 1'b1;
        #1;
        check("midreset_rd_data", rd_data, 32'h0);
        check("midreset_busy_vec", {16'h0, busy_vec}, 32'h0);
        check("midreset_rd_busy", {30'h0, rd_busy}, 32'h0);

        // Write then read from both ports
        drive(1'b1, 4'd3, 16'h1234, 1'b0, 4'd0, 4'd1, 4'd2);
        edge_then_idle(4'd3, 4'd3);
        check("wr_r3_both_ports", rd_data, 32'h12341234);
        check("wr_r3_busy", {30'h0, rd_busy}, 32'h0);

        // Bypass: old r7 value must not leak through
        drive(1'b1, 4'd7, 16'h5A5A, 1'b0, 4'd0, 4'd0, 4'd0);
        edge_then_idle(4'd3, 4'd7);
        check("r7_old_value", {16'h0, rd_data[31:16]}, 32'h00005A5A);
        drive(1'b1, 4'd7, 16'hA5A5, 1'b0, 4'd0, 4'd3, 4'd7);
        check("bypass_port1", rd_data, 32'hA5A51234);
        edge_then_idle(4'd3, 4'd7);
        check("after_bypass_r7", rd_data, 32'hA5A51234);

        // Scoreboard set and clear on r4
        drive(1'b0, 4'd0, 16'h0, 1'b1, 4'd4, 4'd4, 4'd3);
        check("set_same_cycle_rd_busy", {30'h0, rd_busy}, 32'h0);
        check("set_same_cycle_vec", {16'h0, busy_vec}, 32'h0);
        edge_then_idle(4'd4, 4'd4);
        check("set_r4_vec", {16'h0, busy_vec}, 32'h00000010);
        check("set_r4_rd_busy", {30'h0, rd_busy}, 32'h3);
        drive(1'b1, 4'd4, 16'h0042, 1'b0, 4'd0, 4'd4, 4'd3);
        check("clr_r4_bypass", {30'h0, rd_busy}, 32'h0);
        check("clr_r4_bypass_data", rd_data, 32'h12340042);
        check("clr_r4_vec_before", {16'h0, busy_vec}, 32'h00000010);
        edge_then_idle(4'd4, 4'd4);
        check("clr_r4_vec_after", {16'h0, busy_vec}, 32'h0);

        // Collision on r9: data lands and set wins
        drive(1'b1, 4'd9, 16'h0001, 1'b1, 4'd9, 4'd9, 4'd9);
        check("collide_bypass_busy", {30'h0, rd_busy}, 32'h0);
        edge_then_idle(4'd9, 4'd9);
        check("collide_r9_data", rd_data, 32'h00010001);
        check("collide_r9_vec", {16'h0, busy_vec}, 32'h00000200);
        check("collide_r9_rd_busy", {30'h0, rd_busy}, 32'h3);

        // Different addresses in the same cycle
        drive(1'b1, 4'd10, 16'h00AA, 1'b1, 4'd11, 4'd10, 4'd11);
        edge_then_idle(4'd10, 4'd11);
        check("split_vec", {16'h0, busy_vec}, 32'h00000A00);
        check("split_data", rd_data, 32'h000000AA);
        check("split_rd_busy", {30'h0, rd_busy}, 32'h2);

        // Register 0 handling
        drive(1'b1, 4'd0, 16'hFFFF, 1'b1, 4'd0, 4'd0, 4'd0);
`ifdef REGFILE_ZERO_REG_EN
        check("r0_same_data", rd_data, 32'h0);
`else
        check("r0_same_data", rd_data, 32'hFFFFFFFF);
`endif
        check("r0_same_busy", {30'h0, rd_busy}, 32'h0);
        check("r0_same_vec", {16'h0, busy_vec}, 32'h00000A00);
        edge_then_idle(4'd0, 4'd0);
`ifdef REGFILE_ZERO_REG_EN
        check("r0_next_data", rd_data, 32'h0);
        check("r0_next_vec", {16'h0, busy_vec}, 32'h00000A00);
        check("r0_next_busy", {30'h0, rd_busy}, 32'h0);
`else
        check("r0_next_data", rd_data, 32'hFFFFFFFF);
        check("r0_next_vec", {16'h0, busy_vec}, 32'h00000A01);
        check("r0_next_busy", {30'h0, rd_busy}, 32'h3);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
